// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//
// Byte-addressed instruction store with a purely combinational 10-byte fetch
// window and a byte-wide program-load write port.
//
// Ports
//   clk          in   1   single clock, all state changes on its rising edge
//   reset        in   1   synchronous, active-high; clears every byte to 8'h00
//   pc           in  64   byte address of the first byte of the fetch window
//   wr_en        in   1   program-load write strobe
//   wr_addr      in  64   byte address for the program-load write
//   wr_data      in   8   byte value for the program-load write
//   byte0..9     out  8   byteN = mem[pc+N], or 8'h00 when pc+N is off the end
//   imem_error   out  1   pc lies outside the store
// -----------------------------------------------------------------------------
module instruction_memory #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  byte0,
    output logic [7:0]  byte1,
    output logic [7:0]  byte2,
    output logic [7:0]  byte3,
    output logic [7:0]  byte4,
    output logic [7:0]  byte5,
    output logic [7:0]  byte6,
    output logic [7:0]  byte7,
    output logic [7:0]  byte8,
    output logic [7:0]  byte9,
    output logic        imem_error
);

    localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int          WINDOW    = 10;
    // Address compares are done at 65 bits so pc+N near 2^64-1 cannot wrap
    // around into low memory.
    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    logic [7:0] mem_q [MEM_BYTES];
    logic [7:0] mem_d [MEM_BYTES];

    logic [7:0] rd_bytes [WINDOW];

    // ------------------------------------------------------------------
    // Next-state of the store: reset clears everything and wins over a
    // write on the same edge; out-of-range writes are dropped silently.
    // ------------------------------------------------------------------
    always_comb begin
        logic          wr_hit;
        logic [AW-1:0] wr_idx;

        mem_d  = mem_q;
        wr_hit = wr_en && ({1'b0, wr_addr} < MEM_LIMIT);
        wr_idx = wr_addr[AW-1:0];

        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_d[i] = 8'h00;
            end
        end else if (wr_hit) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Combinational fetch window. Reads come straight from mem_q, so a
    // write becomes visible only after the edge that commits it.
    // ------------------------------------------------------------------
    always_comb begin
        logic [64:0] rd_addr;

        rd_addr = '0;
        for (int n = 0; n < WINDOW; n++) begin
            rd_bytes[n] = 8'h00;
        end

        for (int n = 0; n < WINDOW; n++) begin
            rd_addr = {1'b0, pc} + 65'(n);
            if (rd_addr < MEM_LIMIT) begin
                rd_bytes[n] = mem_q[rd_addr[AW-1:0]];
            end
        end
    end

    assign imem_error = ({1'b0, pc} >= MEM_LIMIT);

    assign byte0 = rd_bytes[0];
    assign byte1 = rd_bytes[1];
    assign byte2 = rd_bytes[2];
    assign byte3 = rd_bytes[3];
    assign byte4 = rd_bytes[4];
    assign byte5 = rd_bytes[5];
    assign byte6 = rd_bytes[6];
    assign byte7 = rd_bytes[7];
    assign byte8 = rd_bytes[8];
    assign byte9 = rd_bytes[9];

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
//
// Self-checking bench for instruction_memory. A plain byte array holds the
// reference contents; expected fetch bytes are derived from it with ordinary
// address arithmetic.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

    localparam int MEM_BYTES = 1024;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  byte0, byte1, byte2, byte3, byte4;
    logic [7:0]  byte5, byte6, byte7, byte8, byte9;
    logic        imem_error;

    always #5 clk = ~clk;

    instruction_memory #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .byte0      (byte0),
        .byte1      (byte1),
        .byte2      (byte2),
        .byte3      (byte3),
        .byte4      (byte4),
        .byte5      (byte5),
        .byte6      (byte6),
        .byte7      (byte7),
        .byte8      (byte8),
        .byte9      (byte9),
        .imem_error (imem_error)
    );

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [MEM_BYTES];
    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] ref_byte(logic [63:0] a, int n);
        logic [64:0] full;
        full = {1'b0, a} + 65'(n);
        if (full < 65'(MEM_BYTES)) return ref_mem[int'(full)];
        return 8'h00;
    endfunction

    function automatic logic ref_err(logic [63:0] a);
        return a >= 64'(MEM_BYTES);
    endfunction

    function automatic logic [7:0] dut_byte(int n);
        case (n)
            0: return byte0;
            1: return byte1;
            2: return byte2;
            3: return byte3;
            4: return byte4;
            5: return byte5;
            6: return byte6;
            7: return byte7;
            8: return byte8;
            default: return byte9;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_read(string tag);
        for (int n = 0; n < 10; n++) begin
            check_val($sformatf("%s.byte%0d", tag, n), 64'(dut_byte(n)), 64'(ref_byte(pc, n)));
        end
        check_val($sformatf("%s.err", tag), 64'(imem_error), 64'(ref_err(pc)));
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle with the given controls; the model commits on the edge.
    task automatic cycle(bit r, bit we, logic [63:0] wa, logic [7:0] wd);
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        end else if (we && wa < 64'(MEM_BYTES)) begin
            ref_mem[int'(wa)] = wd;
        end
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic set_pc(logic [63:0] a);
        pc = a;
        #1;
    endtask

    function automatic logic [63:0] rand_pc();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(0, MEM_BYTES - 1));
            1: return 64'($urandom_range(MEM_BYTES - 12, MEM_BYTES - 1));
            2: return 64'($urandom_range(MEM_BYTES, MEM_BYTES + 20));
            3: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 12));
            4: return {$urandom, $urandom};
            default: return 64'($urandom_range(0, 40));
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    logic [7:0] prog0 [10];

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        pc      = '0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

        // Reset state
        cycle(1'b1, 1'b0, '0, '0);
        set_pc(0);
        check_read("rst_pc0");
        for (int k = 0; k < 4; k++) begin
            set_pc(64'($urandom_range(0, MEM_BYTES - 1)));
            check_read("rst_rand");
        end

        // Short program at 0..9
        prog0 = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 64'(i), prog0[i]);
        set_pc(0);
        check_read("prog0");
        check_val("prog0.lit_b0", 64'(byte0), 64'h30);
        check_val("prog0.lit_b1", 64'(byte1), 64'hF2);
        check_val("prog0.lit_b2", 64'(byte2), 64'h0A);
        check_val("prog0.lit_err", 64'(imem_error), 64'h0);

        // Ramp at 100..109, then an unaligned fetch
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 64'(100 + i), 8'(8'h10 + i));
        set_pc(100);
        check_read("ramp100");
        check_val("ramp100.lit_b9", 64'(byte9), 64'h19);
        set_pc(103);
        check_read("ramp103");
        check_val("ramp103.lit_b0", 64'(byte0), 64'h13);
        check_val("ramp103.lit_b6", 64'(byte6), 64'h19);
        check_val("ramp103.lit_b7", 64'(byte7), 64'h00);

        // Top of the store and beyond
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 64'(1020 + i), 8'(8'hA1 + i));
        set_pc(1020);
        check_read("top1020");
        check_val("top1020.lit_b3", 64'(byte3), 64'hA4);
        check_val("top1020.lit_b4", 64'(byte4), 64'h00);
        set_pc(1024);
        check_read("pc1024");
        check_val("pc1024.lit_err", 64'(imem_error), 64'h1);
        set_pc(64'hFFFF_FFFF_FFFF_FFFF);
        check_read("pc_max");
        check_val("pc_max.lit_err", 64'(imem_error), 64'h1);
        set_pc(64'hFFFF_FFFF_FFFF_FFFA);
        check_read("pc_wrap");

        // Read during write: old value before the edge, new after
        set_pc(0);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 64'd5;
        wr_data = 8'hAB;
        #1;
        check_val("rdw.before", 64'(byte5), 64'h00);
        @(posedge clk);
        ref_mem[5] = 8'hAB;
        #1;
        wr_en = 1'b0;
        check_val("rdw.after", 64'(byte5), 64'hAB);
        check_read("rdw");

        // Out-of-range writes change nothing, including ones whose low bits alias
        cycle(1'b0, 1'b1, 64'd2000, 8'h77);
        cycle(1'b0, 1'b1, 64'h8000_0000_0000_0005, 8'h66);
        cycle(1'b0, 1'b1, 64'd1024 + 64'd2, 8'h44);
        set_pc(0);
        check_read("oor_write");
        check_val("oor_write.lit_b2", 64'(byte2), 64'h0A);

        // Reset beats a same-edge write
        cycle(1'b1, 1'b1, 64'd7, 8'h55);
        set_pc(0);
        check_read("rst_vs_wr");
        check_val("rst_vs_wr.lit_b7", 64'(byte7), 64'h00);

        // Fill with non-zero data, then reset mid-operation
        for (int i = 0; i < MEM_BYTES; i++) cycle(1'b0, 1'b1, 64'(i), 8'($urandom_range(1, 255)));
        set_pc(500);
        check_read("filled500");
        set_pc(1018);
        check_read("filled1018");
        cycle(1'b1, 1'b0, '0, '0);
        set_pc(0);
        check_read("refill_rst0");
        set_pc(500);
        check_read("refill_rst500");
        set_pc(1014);
        check_read("refill_rst1014");
        check_val("refill_rst1014.lit_b9", 64'(byte9), 64'h00);

        // Randomized mix of writes, resets and fetches
        for (int it = 0; it < 400; it++) begin
            logic [63:0] wa;
            bit          r;
            case ($urandom_range(0, 3))
                0: wa = 64'($urandom_range(MEM_BYTES - 12, MEM_BYTES - 1));
                1: wa = {$urandom, $urandom};
                default: wa = 64'($urandom_range(0, MEM_BYTES - 1));
            endcase
            r = ($urandom_range(0, 99) == 0);
            cycle(r, $urandom_range(0, 3) != 0, wa, 8'($urandom));
            set_pc(rand_pc());
            check_read("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter MEM_BYTES, default 1024: byte capacity of the instruction store, addresses 0..MEM_BYTES-1.
REQ-002 Port clk  input  1: single clock; all state updates occur on its rising edge.
REQ-003 Port reset  input  1: reset is synchronous and active-high; it is sampled on the rising edge of clk.
REQ-004 Port pc  input  64: byte address of the instruction to fetch.
REQ-005 Port wr_en  input  1: program-load write strobe.
REQ-006 Port wr_addr  input  64: byte address for a program-load write.
REQ-007 Port wr_data  input  8: byte value for a program-load write.
REQ-008 Ports byte0..byte9  output  8 each: byteN is the memory byte at address pc+N.
REQ-009 Port imem_error  output  1: set when pc is outside the store.

Function
REQ-010 Storage: MEM_BYTES bytes, byte-addressed. Reads and writes are little-endian by address, with no word alignment requirement.
REQ-011 Read path is purely combinational. byte0..byte9 and imem_error follow pc and the stored contents with zero clock latency.
REQ-012 byteN = mem[pc+N] when pc+N < MEM_BYTES; otherwise byteN = 8'h00.
REQ-013 pc+N is computed at 65-bit width, so an address near 2^64-1 does not wrap to low memory and reads as 8'h00.
REQ-014 imem_error = 1 iff pc >= MEM_BYTES (full 64-bit compare); otherwise 0.
REQ-015 If pc < MEM_BYTES but pc+9 >= MEM_BYTES, imem_error = 0. The bytes past the end read 8'h00.
REQ-016 Write: on a rising edge with reset=0, wr_en=1 and wr_addr < MEM_BYTES, the block sets mem[wr_addr] <= wr_data.
REQ-017 A write with wr_addr >= MEM_BYTES is ignored silently, changes no state and does not affect imem_error.
REQ-018 Read-during-write: outputs show the old byte before the edge and the new byte immediately after it. There is no bypass.
REQ-019 Outputs contain no X for any pc value, including out-of-range and 64-bit extreme values.
REQ-020 The block has no other state. There is no pipeline register on the read path.

Reset
REQ-021 On a rising edge with reset=1, every memory byte becomes 8'h00, i.e. the store is filled with halt opcodes.
REQ-022 reset has priority over wr_en on the same edge: the write is discarded.
REQ-023 After reset, for any pc < MEM_BYTES: byte0..byte9 = 8'h00 and imem_error = 0.
REQ-024 Before the first reset, memory contents are unspecified. Benches shall apply reset before checking reads.
REQ-025 Reset asserted mid-operation behaves identically to the initial reset.
REQ-026 Reset has no effect on the combinational read timing.

Verification
REQ-027 Reset, then load 8'h30, 8'hF2, 8'h0A, then 7×8'h00 at addresses 0..9; set pc=0.
  -> byte0=30, byte1=F2, byte2=0A, byte3..byte9=00, imem_error=0.
REQ-028 Load addresses 100..109 with values 0x10..0x19; set pc=100.
  -> byteN = 0x10+N.
  -> Then set pc=103: byte0=13, byte6=19, and byte7..byte9 = whatever the store holds at addresses 110..112 (00 after reset).
REQ-029 Set pc=1020 (MEM_BYTES=1024).
  -> byte0..byte3 = mem[1020..1023], byte4..byte9 = 00, imem_error=0.
  -> Then set pc=1024: all bytes 00 and imem_error=1.
  -> Then set pc=64'hFFFF_FFFF_FFFF_FFFF: all bytes 00 and imem_error=1.
REQ-030 Set wr_en=1, wr_addr=5, wr_data=8'hAB and pc=0 in the same cycle.
  -> byte5 holds its old value before the edge and equals AB after the edge.
  -> A following write with wr_addr=2000 changes no byte.
REQ-031 Set reset=1 and wr_en=1 with wr_addr=7, wr_data=8'h55 in the same cycle.
  -> After the edge, mem[7]=00 and every byte for pc=0 is 00.
REQ-032 Fill memory with non-zero data, then assert reset for one cycle.
  -> Reads at pc=0, 500 and 1014 all return 00 with imem_error=0.
